uart_mmio: RTL
==============

UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning entries per RX and TX FIFO; power of two, legal range 2..128.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port addr  input  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 CLEAR.
REQ-005 SHALL have port wr_en  input  1  bus write strobe, one access per asserted cycle.
REQ-006 SHALL have port wdata  input  32  bus write data.
REQ-007 SHALL have port rd_en  input  1  bus read strobe, one access per asserted cycle.
REQ-008 SHALL have port rdata  output  32  registered read data.
REQ-009 SHALL have port rd_valid  output  1  pulses high when rdata holds a read result.
REQ-010 SHALL have port tx_data  output  8  TX FIFO head byte to the UART transmitter.
REQ-011 SHALL have port tx_transmit  output  1  high while the TX FIFO is non-empty.
REQ-012 SHALL have port tx_fetch  input  1  transmitter accepted tx_data this cycle.
REQ-013 SHALL have port rx_data  input  8  byte from the UART receiver.
REQ-014 SHALL have port rx_received  input  1  single-cycle pulse; rx_data valid this cycle.
REQ-015 SHALL have port irq  output  1  level interrupt request.

Function
REQ-016 SHALL have a DATA read (addr 0): pops the RX FIFO; rdata[7:0]=head byte, rdata[31]=1 if a byte was popped; when empty, rdata=0 and no pop occurs.
REQ-017 SHALL have a DATA write: pushes wdata[7:0] into the TX FIFO; when full, the write is dropped and tx_drop (sticky) is set.
REQ-018 SHALL have a STATUS read return: bit0 rx_nonempty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 rx_overrun, bit5 tx_drop, [15:8] rx_count, [23:16] tx_count, others 0.
REQ-019 SHALL have CTRL: write bits[1:0] to {tx_irq_en, rx_irq_en}; read returns them zero-extended.
REQ-020 SHALL have CLEAR: writing bit0=1 clears rx_overrun and bit1=1 clears tx_drop; reads return 0.
REQ-021 SHALL have read latency: rdata/rd_valid update on the edge after rd_en; rd_valid is low when rd_en was low, and rdata holds its last value.
REQ-022 SHALL service rd_en and wr_en asserted together independently, in the same cycle.
REQ-023 SHALL drive tx_transmit = (tx_count != 0) and tx_data = TX head, both from registered state only.
REQ-024 SHALL have tx_fetch high with a non-empty TX FIFO pop exactly one entry that cycle; tx_fetch while empty is ignored.
REQ-025 SHALL have rx_received push rx_data; when full, the byte is dropped and rx_overrun is set sticky.
REQ-026 SHALL have full RX plus a DATA read plus rx_received in the same cycle pop and push, with no overrun, and count unchanged.
REQ-027 SHALL have full TX plus tx_fetch plus a DATA write in the same cycle pop and push, with no drop, and count unchanged.
REQ-028 SHALL have a set request and a CLEAR of the same sticky bit in the same cycle leave the bit set (set wins).
REQ-029 SHALL have FIFO pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1, zero-extended into STATUS fields.
REQ-030 SHALL drive irq = (rx_irq_en & rx_nonempty) | (tx_irq_en & tx_empty) from registered state, with no combinational path from inputs.

Reset
REQ-031 SHALL on reset empty both FIFOs and clear the pointers, counts, rx_overrun, tx_drop, rx_irq_en and tx_irq_en.
REQ-032 SHALL hold outputs at rdata=0, rd_valid=0, tx_transmit=0, tx_data=0, irq=0 from the first edge with reset high.
REQ-033 SHALL ignore all bus, rx_received and tx_fetch inputs while reset is high; reset mid-transfer discards FIFO contents.

Structure
REQ-034 SHALL place the register address constants and STATUS/CTRL/CLEAR bit positions in the shared uart package.
REQ-035 SHALL instantiate one sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count/head) twice, once per direction.

Verification
REQ-036 SHALL verify TX: write 0x41, 0x42, 0x43 to DATA with tx_fetch held low -> tx_transmit=1, tx_data=0x41, STATUS[23:16]=3; three fetch pulses -> bytes leave in order, then tx_transmit=0.
REQ-037 SHALL verify RX: pulse rx_received with 0x5A -> STATUS bit0=1; DATA read -> rdata=0x8000005A with rd_valid one cycle later; second read -> rdata=0.
REQ-038 SHALL verify overrun: 17 rx_received pulses at depth 16 -> rx_count=16, bit4=1, 17th byte lost; CLEAR write 0x1 -> bit4=0.
REQ-039 SHALL verify simultaneity: full RX, DATA read plus rx_received in the same cycle -> rx_count stays 16, bit4 stays 0, new byte popped last.
REQ-040 SHALL verify irq: CTRL=0x2 after reset -> irq=1 (TX empty); one DATA write -> irq=0 next cycle; CTRL=0x1 plus one received byte -> irq=1.
REQ-041 SHALL verify reset: assert reset with 5 bytes in each FIFO -> STATUS reads 0x00000004, tx_transmit=0, irq=0.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART memory-mapped register block: register
// map, STATUS/CTRL/CLEAR bit positions and the STATUS word packer.
package uart_mmio_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_CLEAR  = 2'd3
    } reg_addr_e;

    // STATUS bit positions
    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_FULL     = 3;
    localparam int ST_RX_OVERRUN  = 4;
    localparam int ST_TX_DROP     = 5;
    localparam int ST_RX_COUNT_LO = 8;
    localparam int ST_TX_COUNT_LO = 16;

    // CTRL bit positions
    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;

    // CLEAR bit positions
    localparam int CLR_RX_OVERRUN = 0;
    localparam int CLR_TX_DROP    = 1;

    // DATA read: bit 31 flags that a byte was actually popped
    localparam int DATA_VALID_BIT = 31;

    function automatic logic [31:0] pack_status(
        input logic       rx_nonempty,
        input logic       rx_full,
        input logic       tx_empty,
        input logic       tx_full,
        input logic       rx_overrun,
        input logic       tx_drop,
        input logic [7:0] rx_count,
        input logic [7:0] tx_count
    );
        logic [31:0] w;
        w = '0;
        w[ST_RX_NONEMPTY] = rx_nonempty;
        w[ST_RX_FULL]     = rx_full;
        w[ST_TX_EMPTY]    = tx_empty;
        w[ST_TX_FULL]     = tx_full;
        w[ST_RX_OVERRUN]  = rx_overrun;
        w[ST_TX_DROP]     = tx_drop;
        w[ST_RX_COUNT_LO +: 8] = rx_count;
        w[ST_TX_COUNT_LO +: 8] = tx_count;
        return w;
    endfunction

endpackage

// File: rtl/uart_mmio_sync_fifo.sv
// Synchronous FIFO with registered pointers/count. A pop on an empty FIFO is
// ignored; a push on a full FIFO is accepted only when a pop happens in the
// same cycle, so simultaneous pop+push at full keeps the count unchanged.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Gate the head so an empty FIFO presents zero rather than stale storage
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy update; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped front end for a UART: RX/TX byte FIFOs, sticky error flags,
// interrupt enables and a registered single-cycle read port.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    input  logic        rd_en,
    output logic [31:0] rdata,
    output logic        rd_valid,
    output logic [7:0]  tx_data,
    output logic        tx_transmit,
    input  logic        tx_fetch,
    input  logic [7:0]  rx_data,
    input  logic        rx_received,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rx_full, rx_empty, tx_full, tx_empty;
    logic [CW-1:0] rx_count, tx_count;
    logic [7:0]    rx_head;
    logic          rx_overrun, tx_drop;
    logic          rx_irq_en, tx_irq_en;

    logic is_data, is_ctrl, is_clear;
    logic rx_pop_req, rx_pop_eff, tx_push_req, tx_pop_eff;
    logic ovr_set, drop_set, ovr_clr, drop_clr;
    logic [31:0] rd_word;
    logic unused_wdata;

    assign unused_wdata = ^wdata[31:2];

    assign is_data  = (addr == REG_DATA);
    assign is_ctrl  = (addr == REG_CTRL);
    assign is_clear = (addr == REG_CLEAR);

    assign rx_pop_req  = rd_en & is_data;
    assign rx_pop_eff  = rx_pop_req & ~rx_empty;
    assign tx_push_req = wr_en & is_data;
    assign tx_pop_eff  = tx_fetch & ~tx_empty;

    // A full FIFO only loses data when no pop frees a slot in the same cycle
    assign ovr_set  = rx_received & rx_full & ~rx_pop_eff;
    assign drop_set = tx_push_req & tx_full & ~tx_pop_eff;
    assign ovr_clr  = wr_en & is_clear & wdata[CLR_RX_OVERRUN];
    assign drop_clr = wr_en & is_clear & wdata[CLR_TX_DROP];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_received),
        .pop   (rx_pop_req),
        .din   (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count),
        .head  (rx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push_req),
        .pop   (tx_fetch),
        .din   (wdata[7:0]),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count),
        .head  (tx_data)
    );

    assign tx_transmit = ~tx_empty;
    assign irq = (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty);

    // Read mux over pre-edge state; DATA returns the head being popped
    always_comb begin
        rd_word = '0;
        case (addr)
            REG_DATA: begin
                if (!rx_empty) begin
                    rd_word[7:0]           = rx_head;
                    rd_word[DATA_VALID_BIT] = 1'b1;
                end
            end
            REG_STATUS: rd_word = pack_status(~rx_empty, rx_full, tx_empty, tx_full,
                                              rx_overrun, tx_drop,
                                              8'(rx_count), 8'(tx_count));
            REG_CTRL: begin
                rd_word[CTRL_RX_IRQ_EN] = rx_irq_en;
                rd_word[CTRL_TX_IRQ_EN] = tx_irq_en;
            end
            default: rd_word = '0;
        endcase
    end

    // Registered read port; rdata holds between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rdata <= rd_word;
        end
    end

    // Sticky error flags (set wins over clear) and interrupt enables
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overrun <= 1'b0;
            tx_drop    <= 1'b0;
            rx_irq_en  <= 1'b0;
            tx_irq_en  <= 1'b0;
        end else begin
            rx_overrun <= (rx_overrun & ~ovr_clr) | ovr_set;
            tx_drop    <= (tx_drop & ~drop_clr) | drop_set;
            if (wr_en && is_ctrl) begin
                rx_irq_en <= wdata[CTRL_RX_IRQ_EN];
                tx_irq_en <= wdata[CTRL_TX_IRQ_EN];
            end
        end
    end

endmodule
